event_fifo_arbiter: RTL and testbench
=====================================

// Module: event_fifo_arbiter
// PURPOSE
//  Shares the write port of one event FIFO among N_REQ spike-event producers (conv channel units).
//  Round-robin grant with bounded bursts keeps one producer's events contiguous.
//  Stalls producers on fifo_full; never drops or duplicates an event.
//  Sits between the producer valid/ready ports and the FIFO write_en/write_data/full pins.
// PARAMETERS
//  N_REQ        4   number of requesters (>=2)
//  EVENT_WIDTH  8   event payload bits per requester
//  MAX_BURST    8   max beats per grant (>=1)
//  ID_WIDTH     $clog2(N_REQ)   derived localparam; do not override
// PORTS
//  clk              in   1                      single clock, rising edge
//  rst              in   1                      synchronous, active-high reset
//  req_valid        in   N_REQ                  per-requester event valid
//  req_last         in   N_REQ                  per-requester last beat of burst (qualified by valid)
//  req_data         in   N_REQ*EVENT_WIDTH      packed payloads, requester i at [i*EVENT_WIDTH +: EVENT_WIDTH]
//  req_ready        out  N_REQ                  per-requester accept; one-hot or zero
//  fifo_full        in   1                      FIFO full flag
//  fifo_write_en    out  1                      FIFO write strobe
//  fifo_write_data  out  FIFO_W                 EVENT_WIDTH, or ID_WIDTH+EVENT_WIDTH with tag (see CONFIGURATION)
//  grant_valid      out  1                      a grant is held (state BURST)
//  grant_id         out  ID_WIDTH               current/last grantee
// BEHAVIOUR
//  - Reset (rst=1 at edge): state=IDLE, rr_ptr=0, beat_cnt=0, grant_id=0, grant_valid=0; req_ready=0, fifo_write_en=0 combinationally.
//  - FSM: IDLE, BURST.
//  - IDLE: if any req_valid, grant_id <= first valid index searching from rr_ptr upward, wrapping N_REQ-1->0; beat_cnt<=0; ->BURST. No transfer in IDLE.
//  - BURST: req_ready[grant_id] = !fifo_full; all other ready bits 0.
//  - BURST: fifo_write_en = req_valid[grant_id] & !fifo_full. Beat accepted when write_en=1.
//  - BURST: write_data muxed combinationally from req_data[grant_id]; zero latency through the write path.
//  - Arbitration latency: request-to-first-accept = 1 cycle minimum.
//  - Accepted beat: beat_cnt++.
//  - Release to IDLE, rr_ptr <= (grant_id+1) mod N_REQ, when any of:
//      (a) accepted beat with req_last[grant_id]=1;
//      (b) accepted beat with beat_cnt==MAX_BURST-1;
//      (c) req_valid[grant_id]=0 (producer idle; no transfer that cycle).
//  - fifo_full=1 in BURST: stall; hold grant and beat_cnt; no release by (c) if valid still high.
//  - Simultaneous last and MAX_BURST limit: single release.
//  - Re-arbitration bubble: exactly one IDLE cycle between grants.
//  - A requester never wins twice in a row while another requester is valid.
//  - grant_id holds its value in IDLE.
//  - Reset mid-burst: grant dropped at that edge, no write that cycle; a producer must re-present its unaccepted beat.
//  - Producer contract: req_data/req_last stable while valid & !ready. Violations are asserted in simulation, not corrected.
// CONFIGURATION
//  - EVENT_ARB_SOURCE_TAG_EN defined:
//      FIFO_W = ID_WIDTH+EVENT_WIDTH; fifo_write_data = {grant_id, req_data[grant_id]}.
//      Downstream decodes the source channel from the MSBs.
//  - Undefined: FIFO_W = EVENT_WIDTH; payload only. Arbitration identical in both builds.
// STRUCTURE
//  - Package event_arb_pkg:
//      arb_state_t enum {IDLE, BURST};
//      function fifo_w(tag_en, id_w, ev_w) used to size the FIFO instance consistently.
//  - Sub-module rr_pick: combinational rotate + priority encode.
//      Inputs valid vector and rr_ptr; outputs idx and any.
//      Reused by future read-side schedulers.
//  - Burst counter width: $clog2(MAX_BURST+1).
// TESTING
//  1. Reset: rst=1 with all req_valid=1 -> ready=0, write_en=0, grant_valid=0; first grant to id 0 two cycles after rst falls.
//  2. RR fairness: N_REQ=4, all valid, last=1 every beat -> write order ids 0,1,2,3,0 with one IDLE bubble between each.
//  3. Burst cap: req 2 valid 20 beats, last=0, others idle, MAX_BURST=8 -> 8 writes, bubble, 8, bubble, 4; data in order.
//  4. Full stall: fifo_full=1 for 5 cycles mid-burst -> write_en=0 and ready=0 for those cycles; grant kept; next beat resumes, no loss.
//  5. Valid drop: grantee deasserts valid after 3 beats -> IDLE next cycle; pending req 3 granted, rr_ptr = grantee+1.
//  6. Tag build, EVENT_ARB_SOURCE_TAG_EN: req 1 sends 8'hA5 -> fifo_write_data = {2'b01, 8'hA5}.
//  Scoreboard: per-source event order preserved; FIFO never written while full.

Source files
------------

// File: rtl/event_arb_pkg.sv
// Shared types and sizing helpers for the event FIFO write-side arbiter.
// EVENT_ARB_SOURCE_TAG_EN selects the tagged FIFO word (source id in the MSBs).
package event_arb_pkg;

  typedef enum logic {IDLE, BURST} arb_state_t;

`ifdef EVENT_ARB_SOURCE_TAG_EN
  localparam bit SOURCE_TAG_EN = 1'b1;
`else
  localparam bit SOURCE_TAG_EN = 1'b0;
`endif

  // Size of one FIFO word, so the FIFO instance and the arbiter always agree.
  function automatic int fifo_w(bit tag_en, int id_w, int ev_w);
    return tag_en ? id_w + ev_w : ev_w;
  endfunction

endpackage

// File: rtl/event_fifo_arbiter_rr_pick.sv
// Round-robin picker: rotates the valid vector so rr_ptr is at bit 0,
// priority-encodes the lowest set bit, and maps the result back to an index.
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] valid,
  input  logic [W-1:0] rr_ptr,
  output logic [W-1:0] idx,
  output logic         any
);

  localparam int WP = W + 1;

  logic [N-1:0] rot;
  logic [W-1:0] offs;
  logic [W:0]   sum;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    rot  = N'({valid, valid} >> rr_ptr);
    offs = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) offs = W'(k);
    end
    sum = {1'b0, rr_ptr} + {1'b0, offs};
    if (sum >= WP'(N)) sum = sum - WP'(N);
    idx = sum[W-1:0];
    any = |valid;
  end

endmodule

// File: rtl/event_fifo_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one event FIFO write port among N_REQ producers.
// Build option EVENT_ARB_SOURCE_TAG_EN prefixes each written event with the grantee id.
module event_fifo_arbiter
  import event_arb_pkg::*;
#(
  parameter  int N_REQ       = 4,
  parameter  int EVENT_WIDTH = 8,
  parameter  int MAX_BURST   = 8,
  localparam int ID_WIDTH    = $clog2(N_REQ),
  localparam int FIFO_W      = fifo_w(SOURCE_TAG_EN, ID_WIDTH, EVENT_WIDTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ-1:0]             req_last,
  input  logic [N_REQ*EVENT_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]             req_ready,
  input  logic                         fifo_full,
  output logic                         fifo_write_en,
  output logic [FIFO_W-1:0]            fifo_write_data,
  output logic                         grant_valid,
  output logic [ID_WIDTH-1:0]          grant_id
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t          state_q, state_d;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0] grant_id_q, grant_id_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;

  logic [ID_WIDTH-1:0]    pick_idx;
  logic                   pick_any;
  logic                   in_burst, cur_valid, cur_last, accept, release_grant;
  logic [EVENT_WIDTH-1:0] cur_data;

  rr_pick #(.N(N_REQ), .W(ID_WIDTH)) u_rr_pick (
    .valid  (req_valid),
    .rr_ptr (rr_ptr_q),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Reset also masks the handshake so an in-flight beat is never written on the reset edge.
  always_comb begin
    in_burst      = (state_q == BURST) && !rst;
    cur_valid     = req_valid[grant_id_q];
    cur_last      = req_last[grant_id_q];
    cur_data      = req_data[grant_id_q*EVENT_WIDTH +: EVENT_WIDTH];
    accept        = in_burst && cur_valid && !fifo_full;
    release_grant = in_burst &&
                    ((accept && (cur_last || beat_cnt_q == CNT_W'(MAX_BURST - 1))) || !cur_valid);
    req_ready     = '0;
    if (in_burst && !fifo_full) req_ready[grant_id_q] = 1'b1;
    fifo_write_en = accept;
  end

`ifdef EVENT_ARB_SOURCE_TAG_EN
  assign fifo_write_data = {grant_id_q, cur_data};
`else
  assign fifo_write_data = cur_data;
`endif

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_id_d = pick_idx;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        if (accept) beat_cnt_d = beat_cnt_q + 1'b1;
        if (release_grant) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_id_q == ID_WIDTH'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign grant_valid = (state_q == BURST);
  assign grant_id    = grant_id_q;

  // A stalled grantee must keep its beat unchanged until it is accepted or withdrawn.
  property p_stall_stable;
    @(posedge clk) disable iff (rst)
      (state_q == BURST && cur_valid && fifo_full) |=>
        (!cur_valid || ($stable(cur_data) && $stable(cur_last)));
  endproperty
  a_stall_stable: assert property (p_stall_stable);

endmodule

// File: tb/tb_event_fifo_arbiter.sv
// Scoreboard bench for event_fifo_arbiter: producers replay beat tables, expected writes are
// queued when stimulus is loaded and compared in order as the FIFO write strobe fires.
module tb_event_fifo_arbiter;
  import event_arb_pkg::*;

  localparam int N   = 4;
  localparam int EW  = 8;
  localparam int MB  = 8;
  localparam int IDW = $clog2(N);
  localparam int FW  = fifo_w(SOURCE_TAG_EN, IDW, EW);

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [N*EW-1:0] req_data;
  logic            fifo_full, fifo_write_en, grant_valid;
  logic [FW-1:0]   fifo_write_data;
  logic [IDW-1:0]  grant_id;

  event_fifo_arbiter #(.N_REQ(N), .EVENT_WIDTH(EW), .MAX_BURST(MB)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_last        (req_last),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .fifo_full       (fifo_full),
    .fifo_write_en   (fifo_write_en),
    .fifo_write_data (fifo_write_data),
    .grant_valid     (grant_valid),
    .grant_id        (grant_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int             id;
    logic [EW-1:0]  data;
    int             gap;   // cycles since previous write; 0 = not checked
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  logic [EW-1:0] pd [N][32];
  logic          pl [N][32];
  int            plen [N];
  int            pidx [N];
  logic [N-1:0]  acc_s;
  int            cyc = 0;
  int            last_wr = 0;

  function automatic logic [FW-1:0] fmt(int id, logic [EW-1:0] d);
    if (SOURCE_TAG_EN) return FW'({IDW'(id), d});
    return FW'(d);
  endfunction

  function automatic bit busy();
    for (int i = 0; i < N; i++) if (pidx[i] < plen[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic load(input int id, input logic [EW-1:0] d, input logic last, input int gap);
    pd[id][plen[id]] = d;
    pl[id][plen[id]] = last;
    plen[id]++;
    exp_q.push_back('{id: id, data: d, gap: gap});
  endtask

  task automatic clear();
    for (int i = 0; i < N; i++) begin
      plen[i] = 0;
      pidx[i] = 0;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = pidx[i] < plen[i];
      req_last[i]           = req_valid[i] ? pl[i][pidx[i]] : 1'b0;
      req_data[i*EW +: EW]  = req_valid[i] ? pd[i][pidx[i]] : '0;
    end
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy()) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_beats(input int id, input int n, input string tag);
    int t;
    t = 0;
    while (pidx[id] < n && t < 100) begin
      @(posedge clk);
      #2;
      t++;
    end
    check({tag, "_reached"}, pidx[id] >= n, 1);
  endtask

  // Producer side: handshakes seen before the edge retire a beat, the next one appears after it.
  always @(negedge clk) acc_s = req_valid & req_ready;

  always @(posedge clk) begin
    cyc++;
    #1;
    for (int i = 0; i < N; i++) if (acc_s[i]) pidx[i]++;
    acc_s = '0;
    drive();
  end

  // FIFO side: every write is matched against the scoreboard head.
  always @(negedge clk) begin
    check("ready_onehot0", $onehot0(req_ready), 1);
    check("wr_en_vs_handshake", fifo_write_en, |(req_valid & req_ready));
    if (fifo_write_en) begin
      check("write_while_full", fifo_full, 0);
      if (exp_q.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("wr_data", fifo_write_data, fmt(e.id, e.data));
        check("wr_id", grant_id, e.id);
        check("wr_ready", req_ready, 1 << e.id);
        if (e.gap != 0) check("wr_gap", cyc - last_wr, e.gap);
      end
      last_wr = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    fifo_full = 1'b0;
    acc_s     = '0;
    clear();
    drive();

    // Reset with everyone requesting, then round-robin with single-beat bursts.
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < N; i++)
        load(i, EW'(16 * i + b), 1'b1, (b == 0 && i == 0) ? 1 : 2);
    repeat (3) begin
      @(negedge clk);
      check("rst_ready", req_ready, 0);
      check("rst_wr_en", fifo_write_en, 0);
      check("rst_grant_valid", grant_valid, 0);
    end
    @(posedge clk);
    #1;
    rst     = 1'b0;
    last_wr = cyc;
    @(negedge clk);
    check("idle_after_rst", grant_valid, 0);
    check("no_write_in_idle", fifo_write_en, 0);
    @(negedge clk);
    check("first_grant_valid", grant_valid, 1);
    check("first_grant_id", grant_id, 0);
    wait_drain("rr");
    clear();

    // Burst cap: one producer, 20 beats, never last -> 8, 8, 4 with a bubble between.
    for (int b = 0; b < 20; b++)
      load(2, EW'(8'h40 + b), 1'b0, (b == 0) ? 0 : ((b % MB == 0) ? 2 : 1));
    wait_drain("burst_cap");
    clear();

    // FIFO full for five cycles after the second beat of a burst.
    for (int b = 0; b < 6; b++)
      load(1, EW'(8'h60 + b), b == 5, (b == 0) ? 0 : ((b == 2) ? 6 : 1));
    wait_beats(1, 2, "stall");
    fifo_full = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("stall_wr_en", fifo_write_en, 0);
      check("stall_ready", req_ready, 0);
      check("stall_grant_valid", grant_valid, 1);
      check("stall_grant_id", grant_id, 1);
    end
    @(posedge clk);
    #2;
    fifo_full = 1'b0;
    wait_drain("stall");
    clear();

    // Grantee drops valid after three beats; a waiting producer takes over after one bubble.
    for (int b = 0; b < 3; b++)
      load(0, EW'(8'h70 + b), 1'b0, (b == 0) ? 0 : 1);
    wait_beats(0, 1, "drop");
    load(3, 8'h3C, 1'b1, 3);
    wait_drain("valid_drop");
    clear();

    // Payload formatting: tagged build carries the source id in the MSBs.
    load(1, 8'hA5, 1'b1, 0);
    begin
      int t;
      t = 0;
      while (!fifo_write_en && t < 20) begin
        @(negedge clk);
        t++;
      end
      check("tag_seen", fifo_write_en, 1);
      check("tag_data", fifo_write_data, SOURCE_TAG_EN ? FW'(10'h1A5) : FW'(8'hA5));
    end
    wait_drain("tag");
    clear();

    // Reset mid-burst: the presented beat is not written and is re-presented afterwards.
    for (int b = 0; b < 4; b++)
      load(2, EW'(8'h80 + b), b == 3, (b == 1 || b == 3) ? 1 : 0);
    wait_beats(2, 2, "mid_rst");
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_wr_en", fifo_write_en, 0);
    check("mid_rst_ready", req_ready, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_grant_dropped", grant_valid, 0);
    wait_drain("mid_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
